// File: rtl/burst_pattern_gen.sv
// Burst error-pattern generator: builds up to 16 consecutive bit-flip positions, one slot per cycle,
// then holds them for a valid/ready handshake. Optional LFSR start position under BURST_PATTERN_RAND_EN.
//   state  | meaning
//   IDLE   | waiting for start; slots retain last pattern
//   BUILD  | writing slot k (0..15), one per cycle
//   HOLD   | pattern valid, waiting for err_ready
module burst_pattern_gen #(
    parameter int          DATA_W    = 128,
    parameter int          MAX_BURST = 16,
    parameter logic [7:0]  NONE_CODE = 8'h80
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  cfg_pos,
    input  logic [4:0]  cfg_len,
    input  logic        cfg_rand,
    output logic        busy,
    output logic        err_valid,
    input  logic        err_ready,
    output logic [7:0]  error_0,
    output logic [7:0]  error_1,
    output logic [7:0]  error_2,
    output logic [7:0]  error_3,
    output logic [7:0]  error_4,
    output logic [7:0]  error_5,
    output logic [7:0]  error_6,
    output logic [7:0]  error_7,
    output logic [7:0]  error_8,
    output logic [7:0]  error_9,
    output logic [7:0]  error_10,
    output logic [7:0]  error_11,
    output logic [7:0]  error_12,
    output logic [7:0]  error_13,
    output logic [7:0]  error_14,
    output logic [7:0]  error_15,
    output logic [15:0] burst_cnt
);

    localparam int K_W = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUILD = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [K_W-1:0] r_k;
    logic [6:0]     r_pos;
    logic [4:0]     r_len;
    logic [7:0]     r_slot [MAX_BURST];
    logic           r_busy;
    logic           r_err_valid;
    logic [15:0]    r_burst_cnt;

    logic           w_accept;
    logic           w_last;
    logic           w_done;
    logic [4:0]     w_len_clamp;
    logic [6:0]     w_pos_sel;
    logic [7:0]     w_sum;
    logic [7:0]     w_wrap;
    logic [7:0]     w_slot_val;

`ifdef BURST_PATTERN_RAND_EN
    logic [6:0]     r_lfsr;

    // x^7 + x^6 + 1, seeded non-zero so the all-zero lock-up state is unreachable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 7'h01;
        end else begin
            r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
        end
    end

    assign w_pos_sel = cfg_rand ? r_lfsr : cfg_pos;
`else
    logic w_unused_cfg_rand;

    assign w_unused_cfg_rand = cfg_rand;
    assign w_pos_sel         = cfg_pos;
`endif

    assign w_len_clamp = (cfg_len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : cfg_len;
    assign w_accept    = (r_state == ST_IDLE)  && start;
    assign w_last      = (r_state == ST_BUILD) && (r_k == K_W'(MAX_BURST - 1));
    assign w_done      = (r_state == ST_HOLD)  && err_ready;

    // Position wrap kept generic for any DATA_W up to 128
    assign w_sum      = {1'b0, r_pos} + 8'(r_k);
    assign w_wrap     = (w_sum >= 8'(DATA_W)) ? (w_sum - 8'(DATA_W)) : w_sum;
    assign w_slot_val = (5'(r_k) < r_len) ? {1'b0, w_wrap[6:0]} : NONE_CODE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_BUILD;
                end
            end
            ST_BUILD: begin
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (err_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k   <= '0;
            r_pos <= '0;
            r_len <= '0;
            for (int i = 0; i < MAX_BURST; i++) begin
                r_slot[i] <= NONE_CODE;
            end
        end else if (w_accept) begin
            r_k   <= '0;
            r_pos <= w_pos_sel;
            r_len <= w_len_clamp;
            for (int i = 0; i < MAX_BURST; i++) begin
                r_slot[i] <= NONE_CODE;
            end
        end else if (r_state == ST_BUILD) begin
            r_slot[r_k] <= w_slot_val;
            r_k         <= r_k + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_err_valid <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_busy <= (w_state_nxt != ST_IDLE);
            if (w_last) begin
                r_err_valid <= 1'b1;
            end else if (w_done) begin
                r_err_valid <= 1'b0;
            end
            if (w_done && (r_burst_cnt != 16'hFFFF)) begin
                r_burst_cnt <= r_burst_cnt + 16'd1;
            end
        end
    end

    assign busy      = r_busy;
    assign err_valid = r_err_valid;
    assign burst_cnt = r_burst_cnt;

    assign error_0  = r_slot[0];
    assign error_1  = r_slot[1];
    assign error_2  = r_slot[2];
    assign error_3  = r_slot[3];
    assign error_4  = r_slot[4];
    assign error_5  = r_slot[5];
    assign error_6  = r_slot[6];
    assign error_7  = r_slot[7];
    assign error_8  = r_slot[8];
    assign error_9  = r_slot[9];
    assign error_10 = r_slot[10];
    assign error_11 = r_slot[11];
    assign error_12 = r_slot[12];
    assign error_13 = r_slot[13];
    assign error_14 = r_slot[14];
    assign error_15 = r_slot[15];

endmodule

// File: tb/tb_burst_pattern_gen.sv
// Randomized self-checking bench for burst_pattern_gen against a behavioural slot/handshake model.
// Define BURST_PATTERN_RAND_EN on both RTL and bench to exercise the LFSR start position.
module tb_burst_pattern_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [6:0]  cfg_pos = '0;
    logic [4:0]  cfg_len = '0;
    logic        cfg_rand = 1'b0;
    logic        err_ready = 1'b0;
    logic        busy;
    logic        err_valid;
    logic [7:0]  err [16];
    logic [15:0] burst_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    // Edges since reset release; the LFSR has advanced once per such edge
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    burst_pattern_gen dut (
        .clk(clk), .rst(rst), .start(start), .cfg_pos(cfg_pos), .cfg_len(cfg_len),
        .cfg_rand(cfg_rand), .busy(busy), .err_valid(err_valid), .err_ready(err_ready),
        .error_0(err[0]),   .error_1(err[1]),   .error_2(err[2]),   .error_3(err[3]),
        .error_4(err[4]),   .error_5(err[5]),   .error_6(err[6]),   .error_7(err[7]),
        .error_8(err[8]),   .error_9(err[9]),   .error_10(err[10]), .error_11(err[11]),
        .error_12(err[12]), .error_13(err[13]), .error_14(err[14]), .error_15(err[15]),
        .burst_cnt(burst_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_slot(input int pos, input int len, input int i);
        int l;
        l = (len > 16) ? 16 : len;
        return (i < l) ? 8'((pos + i) % 128) : 8'h80;
    endfunction

    // Sequence x^7+x^6+1 from seed 1: new bit = s[n-7] xor s[n-6]
    function automatic int lfsr_after(input int n);
        logic [6:0] s;
        s = 7'h01;
        for (int j = 0; j < (n % 127); j++) s = {s[5:0], s[6] ^ s[5]};
        return int'(s);
    endfunction

    task automatic check_slots(input string tag, input int pos, input int len);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_e%0d", tag, i), 32'(err[i]), 32'(exp_slot(pos, len, i)));
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_valid"}, 32'(err_valid), 0);
        chk({tag, "_cnt"}, 32'(burst_cnt), 0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("%s_e%0d", tag, i), 32'(err[i]), 32'h80);
    endtask

    task automatic run_burst(input int pos, input int len, input bit rnd, input int stall, input bit early);
        int p;
        cfg_pos  = 7'(pos);
        cfg_len  = 5'(len);
        cfg_rand = rnd;
`ifdef BURST_PATTERN_RAND_EN
        p = rnd ? lfsr_after(edge_cnt) : pos;
`else
        p = pos;
`endif
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("accept_busy", 32'(busy), 1);
        chk("accept_valid", 32'(err_valid), 0);
        repeat (15) begin @(posedge clk); #1; end
        chk("edge16_valid", 32'(err_valid), 0);
        if (early) err_ready = 1'b1;
        @(posedge clk); #1;
        chk("edge17_valid", 32'(err_valid), 1);
        chk("edge17_busy", 32'(busy), 1);
        check_slots("slot", p, len);
        if (!early) begin
            for (int c = 0; c < stall; c++) begin
                start = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                chk("hold_valid", 32'(err_valid), 1);
                chk("hold_busy", 32'(busy), 1);
                check_slots("hold", p, len);
            end
            err_ready = 1'b1;
        end
        start = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        err_ready = 1'b0;
        exp_cnt++;
        chk("done_valid", 32'(err_valid), 0);
        chk("done_busy", 32'(busy), 0);
        chk("done_cnt", 32'(burst_cnt), 32'(exp_cnt));
        @(posedge clk); #1;
        chk("idle_no_restart", 32'(busy), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        run_burst(10, 3, 1'b0, 0, 1'b0);
        run_burst(126, 4, 1'b0, 2, 1'b0);
        run_burst(50, 20, 1'b0, 0, 1'b1);
        run_burst(7, 0, 1'b0, 5, 1'b0);
        run_burst(120, 16, 1'b0, 1, 1'b0);

        cfg_pos = 7'd40; cfg_len = 5'd9; cfg_rand = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_reset_state("midbuild_rst");
        exp_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        run_burst(33, 5, 1'b0, 0, 1'b0);

`ifdef BURST_PATTERN_RAND_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cnt = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        run_burst(0, 4, 1'b1, 0, 1'b0);
`endif

        for (int n = 0; n < 12; n++)
            run_burst(int'($urandom_range(0, 127)), int'($urandom_range(0, 31)),
                      1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                      1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
